// File: rtl/jlsemi_util_clkmux_sel_ctrl_if.sv
// Request/status bundle between a clock-source requester and the clock-mux
// select sequencer. Signal suffixes are from the sequencer's point of view.
interface jlsemi_util_clkmux_sel_ctrl_if;

    // Requested mux source (0 = clk0, 1 = clk1), level, asynchronous to clk_i
    logic req_sel_i;
    // DFT mode: holds off any new switch sequence while high
    logic dft_test_clk_en_i;
    // Registered select to the clock mux
    logic sel_o;
    // Registered enable to the downstream clock gate
    logic clk_gate_en_o;
    // High while a switch sequence is in progress
    logic busy_o;
    // One-cycle pulse as the gate reopens
    logic done_o;

    // Requester side: drives the request and DFT mode, observes status
    modport master (
        output req_sel_i,
        output dft_test_clk_en_i,
        input  sel_o,
        input  clk_gate_en_o,
        input  busy_o,
        input  done_o
    );

    // Sequencer side: consumes the request, produces select and status
    modport slave (
        input  req_sel_i,
        input  dft_test_clk_en_i,
        output sel_o,
        output clk_gate_en_o,
        output busy_o,
        output done_o
    );

endinterface

// File: rtl/jlsemi_util_clkmux_sel_ctrl.sv
// Glitch-safe clock-mux select sequencer. A source change request is
// synchronized into the always-on clk_i domain, then the downstream gate is
// closed, the select flips while the gate is closed, and the gate reopens.
module jlsemi_util_clkmux_sel_ctrl #(
    parameter int CNT_W        = 4,
    parameter int GATE_OFF_CYC = 4,
    parameter int SWITCH_CYC   = 4,
    parameter bit RST_SEL      = 1'b0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    jlsemi_util_clkmux_sel_ctrl_if.slave     bus
);

    // Reload values: the counter runs from N-1 down to 0, giving N cycles
    localparam logic [CNT_W-1:0] GATE_OFF_LOAD = CNT_W'(GATE_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] SWITCH_LOAD   = CNT_W'(SWITCH_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        GATE_ON  = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               target_q, target_d;
    logic               sel_q,    sel_d;
    logic               gate_q,   gate_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               reqMeta_q;
    logic               reqSync_q;

    // Two-flop synchronizer bringing the asynchronous request into clk_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reqMeta_q <= RST_SEL;
            reqSync_q <= RST_SEL;
        end else begin
            reqMeta_q <= bus.req_sel_i;
            reqSync_q <= reqMeta_q;
        end
    end

    // Sequencer state, settle counter, latched target and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= RST_SEL;
            sel_q    <= RST_SEL;
            gate_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sel_q    <= sel_d;
            gate_q   <= gate_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: the select may only move on the GATE_OFF->SWITCH
    // transition, which is always entered with the gate already closed
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        sel_d    = sel_q;
        gate_d   = gate_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                gate_d = 1'b1;
                busy_d = 1'b0;
                done_d = 1'b0;
                // DFT holds the request pending; it is picked up once DFT drops
                if ((reqSync_q != sel_q) && !bus.dft_test_clk_en_i) begin
                    state_d  = GATE_OFF;
                    gate_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = GATE_OFF_LOAD;
                    target_d = reqSync_q;
                end
            end

            GATE_OFF: begin
                if (cnt_q == '0) begin
                    state_d = SWITCH;
                    sel_d   = target_q;
                    cnt_d   = SWITCH_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SWITCH: begin
                if (cnt_q == '0) begin
                    state_d = GATE_ON;
                    gate_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            GATE_ON: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                gate_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign bus.sel_o         = sel_q;
    assign bus.clk_gate_en_o = gate_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;

endmodule

// File: tb/tb_jlsemi_util_clkmux_sel_ctrl.sv
// Bench for the clock-mux select sequencer. Two instances share the same
// stimulus: one with default timing, one with a 1/16 gate-off/switch split.
// A timeline model (sequence age since the gate fell) predicts every output.
module tb_jlsemi_util_clkmux_sel_ctrl;

    localparam bit RST_SEL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic dft = 1'b0;

    int chkCount = 0;
    int errCount = 0;

    jlsemi_util_clkmux_sel_ctrl_if bus0 ();
    jlsemi_util_clkmux_sel_ctrl_if bus1 ();

    assign bus0.req_sel_i         = req;
    assign bus0.dft_test_clk_en_i = dft;
    assign bus1.req_sel_i         = req;
    assign bus1.dft_test_clk_en_i = dft;

    jlsemi_util_clkmux_sel_ctrl #(
        .CNT_W(4), .GATE_OFF_CYC(4), .SWITCH_CYC(4), .RST_SEL(RST_SEL)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0.slave)
    );

    jlsemi_util_clkmux_sel_ctrl #(
        .CNT_W(4), .GATE_OFF_CYC(1), .SWITCH_CYC(16), .RST_SEL(RST_SEL)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    // Reference model: each instance is either idle (age -1) or at some age
    // counted in clk_i edges since the gate fell.
    int mG[2]      = '{4, 1};
    int mS[2]      = '{4, 16};
    int mAge[2]    = '{-1, -1};
    bit mSel[2]    = '{RST_SEL, RST_SEL};
    bit mTarget[2] = '{RST_SEL, RST_SEL};
    bit reqLine[$] = '{RST_SEL, RST_SEL};

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            mAge[k]    = -1;
            mSel[k]    = RST_SEL;
            mTarget[k] = RST_SEL;
        end
        reqLine = '{RST_SEL, RST_SEL};
    endtask

    task automatic stepModel(input int k, input bit syncVal);
        if (mAge[k] < 0) begin
            if ((syncVal != mSel[k]) && !dft) begin
                mAge[k]    = 0;
                mTarget[k] = syncVal;
            end
        end else begin
            mAge[k] = mAge[k] + 1;
            if (mAge[k] == mG[k])
                mSel[k] = mTarget[k];
            if (mAge[k] > mG[k] + mS[k])
                mAge[k] = -1;
        end
    endtask

    function automatic bit expGate(input int k);
        return !((mAge[k] >= 0) && (mAge[k] < mG[k] + mS[k]));
    endfunction

    function automatic bit expDone(input int k);
        return (mAge[k] == mG[k] + mS[k]);
    endfunction

    function automatic bit expBusy(input int k);
        return (mAge[k] >= 0);
    endfunction

    // Advance the model on every clock edge; reset is asynchronous
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            resetModel();
        end else begin
            bit syncVal;
            syncVal = reqLine[0];
            stepModel(0, syncVal);
            stepModel(1, syncVal);
            void'(reqLine.pop_front());
            reqLine.push_back(req);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        checkOutput("u0.sel",  bus0.sel_o,         mSel[0]);
        checkOutput("u0.gate", bus0.clk_gate_en_o, expGate(0));
        checkOutput("u0.busy", bus0.busy_o,        expBusy(0));
        checkOutput("u0.done", bus0.done_o,        expDone(0));
        checkOutput("u1.sel",  bus1.sel_o,         mSel[1]);
        checkOutput("u1.gate", bus1.clk_gate_en_o, expGate(1));
        checkOutput("u1.busy", bus1.busy_o,        expBusy(1));
        checkOutput("u1.done", bus1.done_o,        expDone(1));
    end

    task automatic applyStimulus(input logic reqVal, input logic dftVal);
        req = reqVal;
        dft = dftVal;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".sel0"},  bus0.sel_o,         RST_SEL);
        checkOutput({tag, ".gate0"}, bus0.clk_gate_en_o, 1'b1);
        checkOutput({tag, ".busy0"}, bus0.busy_o,        1'b0);
        checkOutput({tag, ".done0"}, bus0.done_o,        1'b0);
        checkOutput({tag, ".sel1"},  bus1.sel_o,         RST_SEL);
        checkOutput({tag, ".gate1"}, bus1.clk_gate_en_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        waitEdges(3);
        @(negedge clk);
        rst = 1'b0;
        waitEdges(2);
        checkResetOutputs("reset");

        // Basic switch 0->1: request changes just after edge 0
        $display("[TB] basic switch");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0);
        waitEdges(2);
        checkOutput("basic.gate0@2", bus0.clk_gate_en_o, 1'b1);
        waitEdges(1);
        checkOutput("basic.gate0@3", bus0.clk_gate_en_o, 1'b0);
        checkOutput("basic.busy0@3", bus0.busy_o,        1'b1);
        checkOutput("basic.gate1@3", bus1.clk_gate_en_o, 1'b0);
        checkOutput("basic.sel1@3",  bus1.sel_o,         1'b0);
        waitEdges(1);
        checkOutput("basic.sel1@4",  bus1.sel_o,         1'b1);
        waitEdges(2);
        checkOutput("basic.sel0@6",  bus0.sel_o,         1'b0);
        waitEdges(1);
        checkOutput("basic.sel0@7",  bus0.sel_o,         1'b1);
        checkOutput("basic.gate0@7", bus0.clk_gate_en_o, 1'b0);
        waitEdges(3);
        checkOutput("basic.gate0@10", bus0.clk_gate_en_o, 1'b0);
        checkOutput("basic.done0@10", bus0.done_o,        1'b0);
        waitEdges(1);
        checkOutput("basic.gate0@11", bus0.clk_gate_en_o, 1'b1);
        checkOutput("basic.done0@11", bus0.done_o,        1'b1);
        checkOutput("basic.busy0@11", bus0.busy_o,        1'b1);
        waitEdges(1);
        checkOutput("basic.done0@12", bus0.done_o,        1'b0);
        checkOutput("basic.busy0@12", bus0.busy_o,        1'b0);
        waitEdges(7);
        checkOutput("basic.gate1@19", bus1.clk_gate_en_o, 1'b0);
        waitEdges(1);
        checkOutput("basic.gate1@20", bus1.clk_gate_en_o, 1'b1);
        checkOutput("basic.done1@20", bus1.done_o,        1'b1);

        // Return to source 0, then a request that reverses mid-sequence
        applyStimulus(1'b0, 1'b0);
        waitEdges(40);
        $display("[TB] mid-sequence reversal");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0);
        waitEdges(5);
        applyStimulus(1'b0, 1'b0);
        waitEdges(6);
        checkOutput("rev.done0@11", bus0.done_o,        1'b1);
        checkOutput("rev.sel0@11",  bus0.sel_o,         1'b1);
        waitEdges(1);
        checkOutput("rev.gate0@12", bus0.clk_gate_en_o, 1'b1);
        checkOutput("rev.busy0@12", bus0.busy_o,        1'b0);
        waitEdges(1);
        checkOutput("rev.gate0@13", bus0.clk_gate_en_o, 1'b0);
        waitEdges(3);
        checkOutput("rev.sel0@16",  bus0.sel_o,         1'b1);
        waitEdges(1);
        checkOutput("rev.sel0@17",  bus0.sel_o,         1'b0);
        waitEdges(40);

        // DFT mode holds a pending request until it is released
        $display("[TB] dft block");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1);
        waitEdges(30);
        checkOutput("dft.sel0",  bus0.sel_o,         1'b0);
        checkOutput("dft.gate0", bus0.clk_gate_en_o, 1'b1);
        checkOutput("dft.busy0", bus0.busy_o,        1'b0);
        checkOutput("dft.gate1", bus1.clk_gate_en_o, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitEdges(1);
        checkOutput("dft.gate0@rel", bus0.clk_gate_en_o, 1'b0);
        checkOutput("dft.gate1@rel", bus1.clk_gate_en_o, 1'b0);
        waitEdges(40);
        checkOutput("dft.sel0@end", bus0.sel_o, 1'b1);

        // Reset while in SWITCH with the select already flipped
        applyStimulus(1'b0, 1'b0);
        waitEdges(40);
        $display("[TB] reset mid-sequence");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0);
        waitEdges(8);
        checkOutput("rstmid.sel0@8", bus0.sel_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("rstmid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitEdges(2);
        checkOutput("rstmid.gate0@2", bus0.clk_gate_en_o, 1'b1);
        waitEdges(1);
        checkOutput("rstmid.gate0@3", bus0.clk_gate_en_o, 1'b0);
        checkOutput("rstmid.gate1@3", bus1.clk_gate_en_o, 1'b0);
        waitEdges(40);

        // Randomized requests, DFT toggling and occasional resets
        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                applyStimulus(~req, dft);
            if ($urandom_range(0, 19) == 0)
                applyStimulus(req, ~dft);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                checkResetOutputs("rand.rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end
        applyStimulus(req, 1'b0);
        waitEdges(30);

        $display("End of test - %0d assertions evaluated, %0d failures", chkCount, errCount);
        $finish;
    end

endmodule
